// File: rtl/monitor_output_collector.sv
// Captures active monitor outputs into timestamped records, buffers them in a FIFO and
// serialises each record as a header word followed by the active values on a 64-bit stream.
module monitor_output_collector #(
  parameter int NUM_OUT = 3,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 48,
  parameter int DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_OUT*DATA_W-1:0]   out_val,
  input  logic [NUM_OUT-1:0]          out_aktv,
  output logic [63:0]                 m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_VAL} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [TS_W-1:0]             r_ts;
  logic [PTR_W-1:0]            r_wptr;
  logic [PTR_W-1:0]            r_rptr;
  logic [LVL_W-1:0]            r_level;
  logic                        r_overflow;
  logic [15:0]                 r_drop_cnt;

  logic [TS_W-1:0]             r_mem_ts   [DEPTH];
  logic [NUM_OUT-1:0]          r_mem_mask [DEPTH];
  logic [NUM_OUT*DATA_W-1:0]   r_mem_val  [DEPTH];

  logic [TS_W-1:0]             r_hold_ts;
  logic [NUM_OUT-1:0]          r_hold_mask;
  logic [NUM_OUT*DATA_W-1:0]   r_hold_val;
  logic [IDX_W-1:0]            r_idx;

  logic                        w_capture;
  logic                        w_push;
  logic                        w_drop;
  logic                        w_pop;
  logic [IDX_W-1:0]            w_idx_nxt;
  logic [63:0]                 w_hdr;
  logic signed [DATA_W-1:0]    w_sel;
  logic [63:0]                 w_ext;
  logic                        w_is_last;

  function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_OUT-1:0] m);
    logic found;
    f_lowest = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (!found && m[i]) begin
        f_lowest = IDX_W'(i);
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] f_next(input logic [NUM_OUT-1:0] m,
                                             input logic [IDX_W-1:0]   cur);
    logic found;
    f_next = cur;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (!found && m[i] && (i > 32'(cur))) begin
        f_next = IDX_W'(i);
        found  = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] f_highest(input logic [NUM_OUT-1:0] m);
    f_highest = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (m[i]) f_highest = IDX_W'(i);
    end
  endfunction

  // Fullness is judged on the pre-edge level, so a pop on the same edge cannot rescue a push at full.
  assign w_capture = en & (|out_aktv);
  assign w_push    = w_capture & (r_level < LVL_W'(DEPTH));
  assign w_drop    = w_capture & ~w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ts[r_wptr]   <= r_ts;
      r_mem_mask[r_wptr] <= out_aktv;
      r_mem_val[r_wptr]  <= out_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (en)     r_ts   <= r_ts + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_ts   <= '0;
      r_hold_mask <= '0;
      r_hold_val  <= '0;
      r_idx       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) begin
        r_hold_ts   <= r_mem_ts[r_rptr];
        r_hold_mask <= r_mem_mask[r_rptr];
        r_hold_val  <= r_mem_val[r_rptr];
      end
    end
  end

  always_comb begin
    w_hdr                = '0;
    w_hdr[TS_W-1:0]      = r_hold_ts;
    w_hdr[56 +: NUM_OUT] = r_hold_mask;
  end

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (32'(r_idx) == i) w_sel = r_hold_val[i*DATA_W +: DATA_W];
    end
  end

  assign w_ext     = 64'(w_sel);
  assign w_is_last = (r_idx == f_highest(r_hold_mask));

  // Outputs decode only registered state, keeping m_ready off the m_valid path.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = w_hdr;
        if (m_ready) begin
          w_state_nxt = S_VAL;
          w_idx_nxt   = f_lowest(r_hold_mask);
        end
      end
      S_VAL: begin
        m_valid = 1'b1;
        m_data  = w_ext;
        m_last  = w_is_last;
        if (m_ready) begin
          if (w_is_last) w_state_nxt = S_IDLE;
          else           w_idx_nxt   = f_next(r_hold_mask, r_idx);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_monitor_output_collector.sv
// Randomised bench for monitor_output_collector: a record/word-queue model predicts every
// output each cycle, and directed scenarios pin exact stream words.
module tb_monitor_output_collector;

  localparam int NUM_OUT = 3;
  localparam int DATA_W  = 64;
  localparam int TS_W    = 48;
  localparam int DEPTH   = 16;

  typedef struct {
    logic [TS_W-1:0]           ts;
    logic [NUM_OUT-1:0]        mask;
    logic [NUM_OUT*DATA_W-1:0] vals;
  } rec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      en = 1'b0;
  logic [NUM_OUT*DATA_W-1:0] out_val = '0;
  logic [NUM_OUT-1:0]        out_aktv = '0;
  logic                      m_ready = 1'b0;
  logic [63:0]               m_data;
  logic                      m_valid;
  logic                      m_last;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      overflow;
  logic [15:0]               drop_cnt;

  int checks = 0;
  int errors = 0;

  rec_t            m_fifo[$];
  word_t           m_cur[$];
  word_t           acc[$];
  logic [TS_W-1:0] m_ts = '0;
  logic            m_ovf = 1'b0;
  int              m_drop = 0;

  monitor_output_collector #(
    .NUM_OUT(NUM_OUT),
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .out_val   (out_val),
    .out_aktv  (out_aktv),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // A record becomes header + one word per set mask bit, ascending, last on the highest.
  function automatic void expand(input rec_t r);
    word_t w;
    int    hi;
    logic signed [DATA_W-1:0] sv;
    hi = 0;
    for (int i = 0; i < NUM_OUT; i++) if (r.mask[i]) hi = i;
    w.data = (64'(r.mask) << 56) | 64'(r.ts);
    w.last = 1'b0;
    m_cur.push_back(w);
    for (int i = 0; i < NUM_OUT; i++) begin
      if (r.mask[i]) begin
        sv     = r.vals[i*DATA_W +: DATA_W];
        w.data = 64'(sv);
        w.last = (i == hi);
        m_cur.push_back(w);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_cur.delete();
      m_ts   = '0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      rec_t r;
      logic cap, ok;
      cap    = en && (out_aktv != '0);
      ok     = cap && (m_fifo.size() < DEPTH);
      r.ts   = m_ts;
      r.mask = out_aktv;
      r.vals = out_val;
      if (m_cur.size() > 0) begin
        if (m_ready) void'(m_cur.pop_front());
      end else if (m_fifo.size() > 0) begin
        expand(m_fifo.pop_front());
      end
      if (ok) m_fifo.push_back(r);
      if (cap && !ok) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (en) m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    word_t w;
    chk("m_valid", 64'(m_valid), 64'(m_cur.size() > 0));
    if (m_cur.size() > 0) begin
      chk("m_data", m_data, m_cur[0].data);
      chk("m_last", 64'(m_last), 64'(m_cur[0].last));
    end
    chk("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (m_valid && m_ready) begin
      w.data = m_data;
      w.last = m_last;
      acc.push_back(w);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    bit done;
    done     = 1'b0;
    out_aktv = '0;
    m_ready  = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
      cyc();
      if (m_cur.size() == 0 && m_fifo.size() == 0) done = 1'b1;
    end
    m_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout actual=busy required=empty budget=%0d", budget);
    end
  endtask

  function automatic int count_last();
    int n;
    n = 0;
    foreach (acc[i]) if (acc[i].last) n++;
    return n;
  endfunction

  task automatic rand_vals();
    for (int i = 0; i < NUM_OUT; i++) out_val[i*DATA_W +: DATA_W] = {$urandom, $urandom};
  endtask

  initial begin
    logic [TS_W-1:0] t0;
    logic [63:0]     hw;
    repeat (3) cyc();
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_last", 64'(m_last), 64'h0);
    chk("rst_fifo_level", 64'(fifo_level), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);

    // Scenario 1: full mask captured at ts=5.
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (5) cyc();
    acc.delete();
    out_aktv = 3'b111;
    out_val  = {64'd3, 64'd2, 64'd1};
    cyc();
    drain(50, 1'b0);
    chk("s1_words", 64'(acc.size()), 64'd4);
    if (acc.size() >= 4) begin
      chk("s1_hdr", acc[0].data, 64'h0700_0000_0000_0005);
      chk("s1_hdr_last", 64'(acc[0].last), 64'h0);
      chk("s1_v0", acc[1].data, 64'd1);
      chk("s1_v0_last", 64'(acc[1].last), 64'h0);
      chk("s1_v1", acc[2].data, 64'd2);
      chk("s1_v2", acc[3].data, 64'd3);
      chk("s1_v2_last", 64'(acc[3].last), 64'h1);
    end

    // Scenario 2: single active output with a negative value.
    acc.delete();
    out_aktv = 3'b010;
    out_val  = '0;
    out_val[DATA_W +: DATA_W] = 64'hFFFF_FFFF_FFFF_FFF9;
    cyc();
    drain(50, 1'b0);
    chk("s2_words", 64'(acc.size()), 64'd2);
    if (acc.size() >= 2) begin
      hw = acc[0].data;
      chk("s2_hdr_mask", 64'(hw[63:56]), 64'h02);
      chk("s2_val", acc[1].data, 64'hFFFF_FFFF_FFFF_FFF9);
      chk("s2_val_last", 64'(acc[1].last), 64'h1);
    end

    // Scenario 3: stalled sink, one record held by the serialiser, 16 buffered, 2 dropped.
    acc.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      out_aktv = 3'($urandom_range(1, 7));
      rand_vals();
      cyc();
    end
    out_aktv = '0;
    chk("s3_fifo_level", 64'(fifo_level), 64'd16);
    chk("s3_overflow", 64'(overflow), 64'h1);
    chk("s3_drop_cnt", 64'(drop_cnt), 64'd2);
    drain(400, 1'b0);
    chk("s3_records", 64'(count_last()), 64'd17);

    // Scenario 4: three-word record under random backpressure.
    acc.delete();
    out_aktv = 3'b101;
    rand_vals();
    cyc();
    drain(100, 1'b1);
    chk("s4_words", 64'(acc.size()), 64'd3);
    chk("s4_records", 64'(count_last()), 64'd1);

    // Scenario 5: timestamp frozen while en=0.
    acc.delete();
    m_ready  = 1'b1;
    t0       = m_ts;
    out_aktv = 3'b001;
    rand_vals();
    cyc();
    en       = 1'b0;
    out_aktv = 3'b111;
    repeat (10) cyc();
    en       = 1'b1;
    out_aktv = 3'b001;
    cyc();
    drain(50, 1'b0);
    chk("s5_words", 64'(acc.size()), 64'd4);
    if (acc.size() >= 4) begin
      hw = acc[0].data;
      chk("s5_ts_a", 64'(hw[TS_W-1:0]), 64'(t0));
      hw = acc[2].data;
      chk("s5_ts_b", 64'(hw[TS_W-1:0]), 64'(t0 + 1'b1));
    end

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      out_aktv = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000;
      rand_vals();
      m_ready  = ($urandom_range(0, 3) != 0);
      cyc();
    end
    en = 1'b1;
    drain(600, 1'b0);

    // Scenario 6: reset in the middle of a record.
    m_ready = 1'b0;
    out_aktv = 3'b111;
    repeat (3) begin
      rand_vals();
      cyc();
    end
    out_aktv = '0;
    for (int i = 0; i < 20 && m_cur.size() == 0; i++) cyc();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("s6_valid_at_rst", 64'(m_valid), 64'h0);
    chk("s6_level_at_rst", 64'(fifo_level), 64'h0);
    repeat (2) cyc();
    acc.delete();
    out_aktv = 3'b001;
    rand_vals();
    en = 1'b1; m_ready = 1'b1; rst = 1'b0;
    cyc();
    drain(50, 1'b0);
    chk("s6_words", 64'(acc.size()), 64'd2);
    if (acc.size() >= 2) begin
      chk("s6_hdr", acc[0].data, 64'h0100_0000_0000_0000);
      chk("s6_last", 64'(acc[1].last), 64'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
